// File: rtl/piso_serializer_if.sv
// Load/serial-stream bundle for the PISO serializer.
// Handshake: a word is transferred on a rising edge where load_valid and
// load_ready are both 1; load_valid may be asserted at any time and the
// word is captured only on that edge. On the serial side a bit is consumed
// on each rising edge where shift_en=1 while sout_valid=1; with shift_en=0
// the current bit is held.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;

  // Upstream/downstream environment side
  modport master (
    output din, load_valid, shift_en,
    input  load_ready, sout, sout_valid, sout_first, sout_last
  );

  // Serializer side
  modport slave (
    input  din, load_valid, shift_en,
    output load_ready, sout, sout_valid, sout_first, sout_last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer. A captured word is emitted as WIDTH
// registered bits, MSB or LSB first, one bit per shift_en edge. A new word
// can be accepted on the final bit transfer so frames run back to back.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  piso_serializer_if.slave         io_bus,
  output logic                     o_dbg_state
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_sout;
  logic             r_valid;
  logic             r_first;
  logic             r_last;

  logic             w_at_last;
  logic             w_xfer;
  logic             w_load_ready;
  logic             w_load;
  logic [WIDTH-1:0] w_shifted;
  logic             w_next_bit;
  logic             w_din_bit;
  logic [CW-1:0]    w_cnt_inc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: leave SHIFT only when the last bit goes out with no refill
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load) w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_xfer && w_at_last && !w_load) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: handshake and transfer qualifiers (load_ready is held low during reset)
  always_comb begin
    w_at_last    = (r_cnt == LAST);
    w_xfer       = (r_state == S_SHIFT) && io_bus.shift_en;
    w_load_ready = !rst && ((r_state == S_IDLE) ||
                            ((r_state == S_SHIFT) && w_at_last && io_bus.shift_en));
    w_load       = io_bus.load_valid && w_load_ready;
    o_dbg_state  = (r_state == S_SHIFT);
  end

  // Shift/bit-selection helpers; MSB_FIRST picks the shift direction
  always_comb begin
    w_shifted  = '0;
    w_next_bit = 1'b0;
    w_din_bit  = 1'b0;
    w_cnt_inc  = r_cnt + CW'(1);
    if (MSB_FIRST) begin
      w_shifted  = {r_shreg[WIDTH-2:0], 1'b0};
      w_next_bit = r_shreg[WIDTH-2];
      w_din_bit  = io_bus.din[WIDTH-1];
    end else begin
      w_shifted  = {1'b0, r_shreg[WIDTH-1:1]};
      w_next_bit = r_shreg[1];
      w_din_bit  = io_bus.din[0];
    end
  end

  // Datapath: capture, shift, and registered serial outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_shreg <= io_bus.din;
      r_cnt   <= '0;
      r_sout  <= w_din_bit;
      r_valid <= 1'b1;
      r_first <= 1'b1;
      r_last  <= 1'b0;
    end else if (w_xfer) begin
      if (w_at_last) begin
        r_shreg <= '0;
        r_cnt   <= '0;
        r_sout  <= 1'b0;
        r_valid <= 1'b0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_shreg <= w_shifted;
        r_cnt   <= w_cnt_inc;
        r_sout  <= w_next_bit;
        r_first <= 1'b0;
        r_last  <= (w_cnt_inc == LAST);
      end
    end
  end

  assign io_bus.load_ready = w_load_ready;
  assign io_bus.sout       = r_sout;
  assign io_bus.sout_valid = r_valid;
  assign io_bus.sout_first = r_first;
  assign io_bus.sout_last  = r_last;

endmodule
